sysbus_mem_responder: RTL and testbench

- Memory-side responder for the Sysbus line-fill protocol driven by the core's fetch unit.
- Accepts one 64-byte line request at a time, acknowledges it, and after a fixed access latency streams eight 64-bit beats back on the response channel (reads).
- For writes, it absorbs eight data beats after the acknowledge and returns a single completion beat.
- Backed by an internal word-addressed RAM. Serves as the memory model under the core in simulation and as the template for the real memory controller front end.

---
 rtl/sysbus_pkg.sv | 15 +
 rtl/sysbus_mem_array.sv | 17 +
 rtl/sysbus_mem_responder.sv | 101 ++++++++++
 tb/tb_sysbus_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared Sysbus tag fields, line geometry and responder states
package sysbus_pkg;
    localparam logic READ = 1'b1;
    localparam logic WRITE = 1'b0;
    localparam logic [3:0] MEMORY = 4'h1;
    localparam logic [3:0] MMIO = 4'h2;
    localparam int BEATS_PER_LINE = 8;
    localparam int LINE_BYTES = 64;
    typedef struct packed {
        logic       op;
        logic [3:0] kind;
        logic [7:0] id;
    } tag_t;
    typedef enum logic [2:0] {IDLE, ACK, WAIT, RDATA, WDATA, WDONE} state_t;
endpackage

// File: rtl/sysbus_mem_array.sv
// sysbus_mem_array: single-port 64-bit RAM with synchronous read and write
module sysbus_mem_array #(
  parameter int    WORDS     = 65536,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [63:0]              wdata,
  output logic [63:0]              rdata
);
  logic [63:0] mem [WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus line-fill memory responder with fixed access latency
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int    MEM_WORDS = 65536,
    parameter int    LATENCY   = 4,
    parameter int    TAG_WIDTH = 13,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqcyc,
    input  logic [63:0]          req,
    input  logic [TAG_WIDTH-1:0] reqtag,
    output logic                 reqack,
    output logic                 respcyc,
    output logic [63:0]          resp,
    output logic [TAG_WIDTH-1:0] resptag,
    input  logic                 respack
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = AW - 3;
    localparam int CW = $clog2(LATENCY + 1);
    state_t               state, state_n;
    logic [LW-1:0]        line;
    logic [2:0]           beat, beat_n, rd_beat;
    logic [CW-1:0]        cnt, cnt_n;
    logic [TAG_WIDTH-1:0] tag;
    logic [63:0]          rdata;
    logic                 consume, we, unused_req;

    assign consume    = respcyc & respack;
    // RAM reads one cycle ahead: address the next beat on the cycle the current one is taken
    assign rd_beat    = (state == RDATA && consume) ? beat + 3'd1 : beat;
    assign we         = state == WDATA && reqcyc;
    assign reqack     = state == ACK;
    assign respcyc    = state == RDATA || state == WDONE;
    assign resp       = state == RDATA ? rdata : '0;
    assign resptag    = tag;
    assign unused_req = ^{req[63:AW+3], req[5:0]};

    sysbus_mem_array #(.WORDS(MEM_WORDS), .INIT_FILE(INIT_FILE)) u_mem (
        .clk(clk),
        .we(we),
        .addr({line, rd_beat}),
        .wdata(req),
        .rdata(rdata)
    );

    always_comb begin
        state_n = state;
        beat_n  = beat;
        cnt_n   = cnt;
        unique case (state)
            IDLE: if (reqcyc) begin
                state_n = ACK;
                beat_n  = '0;
            end
            ACK: begin
                if (tag[TAG_WIDTH-1] != READ) state_n = WDATA;
                else if (LATENCY == 1) state_n = RDATA;
                else begin
                    state_n = WAIT;
                    cnt_n   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                cnt_n   = cnt - 1'b1;
                state_n = cnt == CW'(1) ? RDATA : WAIT;
            end
            RDATA: if (consume) begin
                beat_n  = beat + 3'd1;
                state_n = beat == 3'd7 ? IDLE : RDATA;
            end
            WDATA: if (reqcyc) begin
                beat_n  = beat + 3'd1;
                state_n = beat == 3'd7 ? WDONE : WDATA;
            end
            WDONE: state_n = respack ? IDLE : WDONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
            cnt   <= '0;
            tag   <= '0;
            line  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            cnt   <= cnt_n;
            if (state == IDLE && reqcyc) begin
                tag  <= reqtag;
                line <= req[AW+2:6];
            end
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed line read/write transactions checked against a queue-based memory model
module tb_sysbus_mem_responder;
    import sysbus_pkg::*;
    localparam int LAT = 4;
    localparam int MW  = 65536;
    localparam int TW  = 13;

    logic          clk = 1'b0;
    logic          reset, reqcyc, respack, reqack, respcyc;
    logic [63:0]   req, resp;
    logic [TW-1:0] reqtag, resptag;

    always #5 clk = ~clk;

    sysbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .TAG_WIDTH(TW), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
        .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag), .respack(respack)
    );

    typedef struct {
        logic [63:0]   data;
        logic [TW-1:0] tag;
        int            due;
        bit            first;
    } beat_t;

    beat_t         q[$];
    logic [63:0]   model [int];
    logic [63:0]   wd [8];
    logic [63:0]   first_data;
    logic [TW-1:0] first_tag;
    int cyc = 0, ack_cyc = -1, errs = 0, checks = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_tag(input logic op, input logic [3:0] k, input logic [7:0] id);
        return {op, k, id};
    endfunction

    function automatic int line_base(input logic [63:0] a);
        int w = int'((a / 8) % MW);
        return w - (w % 8);
    endfunction

    // Expected response stream: each queued beat must appear in order, on time, and hold until accepted
    always @(negedge clk) if (chk_en) begin
        check("reqack", reqack, cyc == ack_cyc);
        if (q.size() == 0) check("respcyc_idle", respcyc, 0);
        else if (q[0].due >= 0 && cyc < q[0].due) check("respcyc_early", respcyc, 0);
        else begin
            check("respcyc", respcyc, 1);
            if (respcyc) begin
                check("resp", resp, q[0].data);
                check("resptag", resptag, q[0].tag);
                if (respack) begin
                    if (q[0].first) begin
                        first_data = resp;
                        first_tag  = resptag;
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send_addr(input logic [63:0] a, input logic [TW-1:0] t);
        @(posedge clk); #1;
        reqcyc = 1; req = a; reqtag = t; ack_cyc = cyc + 1;
        @(posedge clk); #1;
        reqcyc = 0;
    endtask

    task automatic wait_drain(input int stall_from);
        for (int n = 0; n < 60 && q.size() > 0; n++) begin
            @(posedge clk); #1;
            respack = !(stall_from >= 0 && cyc >= stall_from + 2 && cyc <= stall_from + 4);
        end
        if (q.size() > 0) begin
            check("drain_timeout", 64'(q.size()), 0);
            q.delete();
        end
        respack = 1;
    endtask

    task automatic read_line(input logic [63:0] a, input logic [TW-1:0] t, input bit stall);
        int b = line_base(a);
        int due;
        send_addr(a, t);
        due = ack_cyc + LAT;
        for (int i = 0; i < 8; i++) q.push_back('{model[b + i], t, (i == 0) ? due : -1, i == 0});
        wait_drain(stall ? due : -1);
    endtask

    task automatic write_line(input logic [63:0] a, input logic [TW-1:0] t);
        int b = line_base(a);
        int i = 0;
        bit st = 0;
        send_addr(a, t);
        while (i < 8) begin
            @(posedge clk); #1;
            if (i == 4 && !st) begin
                reqcyc = 0;
                st = 1;
            end else begin
                reqcyc = 1; req = wd[i]; model[b + i] = wd[i]; i++;
            end
        end
        q.push_back('{64'h0, t, cyc + 1, 1'b1});
        @(posedge clk); #1;
        reqcyc = 0;
        wait_drain(-1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int due;
        reset = 1; reqcyc = 1; respack = 1; req = 64'h1000; reqtag = mk_tag(READ, MEMORY, 8'h00);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("rst_reqack", reqack, 0);
            check("rst_respcyc", respcyc, 0);
            check("rst_resp", resp, 0);
            check("rst_resptag", resptag, 0);
        end
        @(posedge clk); #1;
        reset = 0; reqcyc = 0; chk_en = 1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 8; i++) wd[i] = 64'(64'h200 + i) * 64'h0101010101010101;
        write_line(64'h1000, mk_tag(WRITE, MEMORY, 8'h10));
        for (int i = 0; i < 8; i++) wd[i] = 64'(64'h10 + i) * 64'h0101010101010101;
        write_line(64'h80, mk_tag(WRITE, MEMORY, 8'h11));

        read_line(64'h1000, mk_tag(READ, MEMORY, 8'h00), 0);
        check("lit_beat0_0x1000", first_data, 64'h0202020202020200);
        check("lit_tag_0x1000", first_tag, 13'h1100);

        read_line(64'h103B, mk_tag(READ, MEMORY, 8'h05), 0);
        check("lit_beat0_0x103B", first_data, 64'h0202020202020200);
        check("lit_tag_0x103B", first_tag, 13'h1105);

        read_line(64'h1000, mk_tag(READ, MMIO, 8'h22), 1);

        for (int i = 0; i < 8; i++) wd[i] = 64'hA0 + 64'(i);
        write_line(64'h40, mk_tag(WRITE, MEMORY, 8'h33));
        check("lit_wdone_resp", first_data, 64'h0);
        read_line(64'h40, mk_tag(READ, MEMORY, 8'h34), 0);
        check("lit_beat0_0x40", first_data, 64'hA0);

        send_addr(64'h1000, mk_tag(READ, MEMORY, 8'h44));
        due = ack_cyc + LAT;
        for (int i = 0; i < 8; i++) q.push_back('{model[line_base(64'h1000) + i], mk_tag(READ, MEMORY, 8'h44), (i == 0) ? due : -1, 1'b0});
        repeat (LAT + 2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0; q.delete();
        repeat (3) @(posedge clk);

        send_addr(64'(MW) * 8 + 64'h80, mk_tag(READ, MEMORY, 8'h55));
        due = ack_cyc + LAT;
        for (int i = 0; i < 8; i++) q.push_back('{model[16 + i], mk_tag(READ, MEMORY, 8'h55), (i == 0) ? due : -1, i == 0});
        repeat (LAT + 2) @(posedge clk);
        #1;
        reqcyc = 1; req = 64'h1000; reqtag = mk_tag(READ, MEMORY, 8'h66); ack_cyc = due + 9;
        for (int i = 0; i < 8; i++) q.push_back('{model[line_base(64'h1000) + i], mk_tag(READ, MEMORY, 8'h66), (i == 0) ? due + 9 + LAT : -1, 1'b0});
        repeat (7) @(posedge clk);
        #1 reqcyc = 0;
        wait_drain(-1);
        check("lit_beat0_wrap", first_data, 64'h1010101010101010);
        check("lit_tag_wrap", first_tag, 13'h1155);

        repeat (3) @(posedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
